fir_param_engine: RTL and testbench
===================================

Name: fir_param_engine

Overview:
Parametrised, fully pipelined FIR engine. It is the successor to the fixed 5-tap, 8-bit moving-sum filter pair inside fir_top.
- Reads LEN signed samples from the shared dual-port sample memory (port A, registered read).
- Applies TAPS programmable coefficients, then rounds and saturates.
- Writes results back through port B at DST_BASE, at one sample per cycle.
- Reports cycle count and saturation count for performance comparison.

Parameters:
- DATA_W, 8: sample and result width, signed.
- COEF_W, 8: coefficient width, signed.
- TAPS, 5: number of filter taps (>=2).
- ADDR_W, 10: memory address width.
- SRC_BASE, 0: first input sample address.
- DST_BASE, 512: first output address.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: run request, sampled only in IDLE.
- len, input, ADDR_W: number of samples to process, latched on start.
- coef_we, input, 1: coefficient write strobe.
- coef_idx, input, $clog2(TAPS): coefficient index k (h[k] multiplies x[n-k]).
- coef_data, input, COEF_W: coefficient value.
- mem_addr_a, output, ADDR_W: read address. Data returns on mem_data_out_a one cycle later.
- mem_data_out_a, input, DATA_W: read data.
- mem_addr_b, output, ADDR_W: write address.
- mem_we_b, output, 1: write enable.
- mem_data_in_b, output, DATA_W: write data.
- busy, output, 1: high from the cycle after start is accepted until done.
- done, output, 1: one-cycle completion pulse.
- cycle_count, output, 32: cycles of the last or current run.
- sat_count, output, 16: saturated outputs in the last or current run; sticks at 0xFFFF.

Behaviour:
Reset (rst=0, asynchronous):
- State goes to IDLE.
- All outputs clear to 0.
- Coefficients reset to 1, which reproduces the legacy moving sum.
- Pipeline contents are discarded and the history is zeroed.
- Takes effect mid-run with no memory write after assertion.

FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- Cycle 0: start=1 in IDLE is sampled. len is latched, cycle_count and sat_count clear, history clears.
- RUN, cycles 1..len: mem_addr_a = SRC_BASE + i (mod 2^ADDR_W) for i = 0..len-1. One read per cycle.
- Pipeline, fixed latency:
  - Read data arrives at cycle i+2.
  - Window shift register is valid at i+3.
  - Products are registered at i+4.
  - Adder-tree sum is registered at i+5.
  - Round/saturate output is registered and written at i+6: mem_we_b=1, mem_addr_b = DST_BASE + i (mod 2^ADDR_W).
- DRAIN: entered after the last read issue. Leaves when the final write (cycle len+5) completes.
- DONE: done=1 for exactly one cycle, at cycle len+6. busy drops in the same cycle. Return to IDLE follows.
- len=0: no reads or writes; done pulses at cycle 1.
- cycle_count:
  - Increments every cycle while busy, with the pulse cycle included.
  - Equals len+6 at done (1 when len=0).
  - Holds its value until the next accepted start.
- Zero history: x[n-k] for n-k < 0 is 0. Earlier memory contents are never used.

Arithmetic:
- Accumulator width is ACC_W = DATA_W + COEF_W + $clog2(TAPS), with full signed precision.
- Rounding: if SHIFT>0, add 2^(SHIFT-1), then apply an arithmetic shift right by SHIFT.
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Each clamped sample increments sat_count.

Ignored inputs:
- start while busy is ignored.
- coef_we while busy is ignored.
- coef_we in IDLE writes on the same edge. Writing the same index twice gives last-write-wins.
- A coefficient write and start on the same edge are both accepted; the run uses the new value.

Test Plan:
- Impulse: mem[0]=1, mem[1..7]=0, coefs h0..h4 = 1,2,3,4,5, len=8 -> mem[512..519] = 1,2,3,4,5,0,0,0; sat_count=0; done at cycle 14; cycle_count=14.
- Saturation: reset coefs (all 1), mem[0..4]=64, mem[5..9]=0, len=10 -> outputs 64,127,127,127,127,127,127,127,64,0; sat_count=7; cycle_count=16.
- Rounding (SHIFT=2 instance), h0=1, others 0: x = 6, -6, 1, -2 -> y = 2, -1, 0, 0.
- len=0: start -> done pulses at cycle 1; mem_we_b never asserted; cycle_count=1.
- Start while busy: second start mid-run is ignored; write count equals the first len. A coef_we issued mid-run does not change later outputs.
- Reset mid-run: rst=0 at cycle 5 of a len=20 run -> done=0, busy=0, mem_we_b=0, cycle_count=0 immediately. A new run after release produces correct results with default coefficients.

Source files
------------

// File: rtl/fir_param_engine_if.sv
// rtl/fir_param_engine_if.sv - memory port bundle between the FIR engine and the dual-port sample memory
// Ports (master = engine side):
//   mem_addr_a     read address, port A (data returns one cycle later)
//   mem_data_out_a read data, port A
//   mem_addr_b     write address, port B
//   mem_we_b       write enable, port B
//   mem_data_in_b  write data, port B
interface fir_param_engine_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic        [ADDR_W-1:0] mem_addr_a;
    logic signed [DATA_W-1:0] mem_data_out_a;
    logic        [ADDR_W-1:0] mem_addr_b;
    logic                     mem_we_b;
    logic signed [DATA_W-1:0] mem_data_in_b;

    modport master (
        output mem_addr_a,
        input  mem_data_out_a,
        output mem_addr_b,
        output mem_we_b,
        output mem_data_in_b
    );

    modport slave (
        input  mem_addr_a,
        output mem_data_out_a,
        input  mem_addr_b,
        input  mem_we_b,
        input  mem_data_in_b
    );
endinterface

// File: rtl/fir_param_engine.sv
// rtl/fir_param_engine.sv - pipelined programmable FIR over the shared sample memory
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, len          run request (sampled in IDLE) and sample count
//   coef_we/idx/data    coefficient write port (accepted while not busy)
//   mem                 memory bundle: port A reads, port B writes
//   busy, done          run in progress, one-cycle completion pulse
//   cycle_count         cycles of the last/current run
//   sat_count           clamped outputs of the last/current run (sticky at max)
module fir_param_engine #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int TAPS     = 5,
    parameter int ADDR_W   = 10,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 512,
    parameter int SHIFT    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          len,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_idx,
    input  logic signed [COEF_W-1:0]   coef_data,
    fir_param_engine_if.master         mem,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                cycle_count,
    output logic [15:0]                sat_count
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(TAPS);
    // One guard bit so adding the rounding constant cannot overflow.
    localparam int RND_W  = ACC_W + 1;
    localparam logic signed [RND_W-1:0] RND_C = RND_W'((1 << SHIFT) >> 1);
    localparam logic signed [RND_W-1:0] MAX_C = RND_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [RND_W-1:0] MIN_C = RND_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         len_q, len_d;
    logic [ADDR_W-1:0]         rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0]         wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0]         addr_b_q, addr_b_d;
    logic                      dat_v_q, dat_v_d;
    logic                      win_v_q, win_v_d;
    logic                      prod_v_q, prod_v_d;
    logic                      sum_v_q, sum_v_d;
    logic                      we_q, we_d;
    logic signed [DATA_W-1:0]  win_q  [TAPS];
    logic signed [DATA_W-1:0]  win_d  [TAPS];
    logic signed [COEF_W-1:0]  h_q    [TAPS];
    logic signed [COEF_W-1:0]  h_d    [TAPS];
    logic signed [PROD_W-1:0]  prod_q [TAPS];
    logic signed [PROD_W-1:0]  prod_d [TAPS];
    logic signed [ACC_W-1:0]   sum_q, sum_d;
    logic signed [DATA_W-1:0]  dout_q, dout_d;
    logic [31:0]               cyc_q, cyc_d;
    logic [15:0]               sat_q, sat_d;

    logic                      accept;
    logic                      run_last;
    logic signed [RND_W-1:0]   rnd_v;
    logic signed [DATA_W-1:0]  sat_v;
    logic                      sat_hit;

    assign accept   = (state_q == S_IDLE) && start;
    assign run_last = (rd_idx_q + ADDR_W'(1)) == len_q;

    // State register and all datapath flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            addr_b_q <= '0;
            dat_v_q  <= 1'b0;
            win_v_q  <= 1'b0;
            prod_v_q <= 1'b0;
            sum_v_q  <= 1'b0;
            we_q     <= 1'b0;
            sum_q    <= '0;
            dout_q   <= '0;
            cyc_q    <= '0;
            sat_q    <= '0;
            for (int k = 0; k < TAPS; k++) begin
                win_q[k]  <= '0;
                prod_q[k] <= '0;
                h_q[k]    <= COEF_W'(1);
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            rd_idx_q <= rd_idx_d;
            wr_idx_q <= wr_idx_d;
            addr_b_q <= addr_b_d;
            dat_v_q  <= dat_v_d;
            win_v_q  <= win_v_d;
            prod_v_q <= prod_v_d;
            sum_v_q  <= sum_v_d;
            we_q     <= we_d;
            sum_q    <= sum_d;
            dout_q   <= dout_d;
            cyc_q    <= cyc_d;
            sat_q    <= sat_d;
            win_q    <= win_d;
            prod_q   <= prod_d;
            h_q      <= h_d;
        end
    end

    // Next state. DRAIN ends while the final write is on the bus: the
    // pipeline has no bubbles, so that is the only cycle with a write
    // pending and nothing left in the sum stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (run_last) state_d = S_DRAIN;
            S_DRAIN: if (we_q && !sum_v_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // Round then clamp the registered accumulator.
    always_comb begin
        rnd_v   = (RND_W'(sum_q) + RND_C) >>> SHIFT;
        sat_hit = 1'b1;
        if (rnd_v > MAX_C) begin
            sat_v = MAX_C[DATA_W-1:0];
        end else if (rnd_v < MIN_C) begin
            sat_v = MIN_C[DATA_W-1:0];
        end else begin
            sat_v   = rnd_v[DATA_W-1:0];
            sat_hit = 1'b0;
        end
    end

    // Pipeline: read issue -> data -> window -> products -> sum -> write.
    always_comb begin
        len_d    = len_q;
        rd_idx_d = rd_idx_q;
        wr_idx_d = wr_idx_q;
        addr_b_d = addr_b_q;
        dout_d   = dout_q;
        cyc_d    = cyc_q;
        sat_d    = sat_q;
        h_d      = h_q;
        win_d    = win_q;
        dat_v_d  = (state_q == S_RUN);
        win_v_d  = dat_v_q;
        prod_v_d = win_v_q;
        sum_v_d  = prod_v_q;
        we_d     = sum_v_q;

        // A write on the start edge lands before the first product uses it.
        if (coef_we && !busy && (int'(coef_idx) < TAPS)) begin
            h_d[coef_idx] = coef_data;
        end

        if (accept) begin
            len_d    = len;
            rd_idx_d = '0;
            wr_idx_d = '0;
            cyc_d    = 32'd1;
            sat_d    = '0;
            // Fresh zero history: no sample from a previous run leaks in.
            for (int k = 0; k < TAPS; k++) begin
                win_d[k] = '0;
            end
        end else begin
            if (busy) cyc_d = cyc_q + 32'd1;
            if (state_q == S_RUN) rd_idx_d = rd_idx_q + ADDR_W'(1);
            if (dat_v_q) begin
                win_d[0] = mem.mem_data_out_a;
                for (int k = 1; k < TAPS; k++) begin
                    win_d[k] = win_q[k-1];
                end
            end
            if (sum_v_q) begin
                addr_b_d = ADDR_W'(DST_BASE) + wr_idx_q;
                wr_idx_d = wr_idx_q + ADDR_W'(1);
                dout_d   = sat_v;
                if (sat_hit && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
            end
        end

        for (int k = 0; k < TAPS; k++) begin
            prod_d[k] = PROD_W'(win_q[k]) * PROD_W'(h_q[k]);
        end

        sum_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            sum_d = sum_d + ACC_W'(prod_q[k]);
        end
    end

    assign mem.mem_addr_a    = (state_q == S_RUN) ? (ADDR_W'(SRC_BASE) + rd_idx_q) : '0;
    assign mem.mem_addr_b    = addr_b_q;
    assign mem.mem_we_b      = we_q;
    assign mem.mem_data_in_b = dout_q;
    assign cycle_count       = cyc_q;
    assign sat_count         = sat_q;
endmodule

// File: tb/tb_fir_param_engine.sv
// tb/tb_fir_param_engine.sv - self-checking bench for fir_param_engine (SHIFT=0 and SHIFT=2 instances)
module tb_fir_param_engine;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start0 = 1'b0, start1 = 1'b0, coef_we = 1'b0;
    logic [AW-1:0]     len = '0;
    logic [2:0]        coef_idx = '0;
    logic signed [7:0] coef_data = '0;
    logic              busy0, busy1, done0, done1;
    logic [31:0]       cc0, cc1;
    logic [15:0]       sc0, sc1;

    fir_param_engine_if #(.ADDR_W(AW), .DATA_W(DW)) m0();
    fir_param_engine_if #(.ADDR_W(AW), .DATA_W(DW)) m1();

    fir_param_engine #(.SHIFT(0)) u0 (
        .clk(clk), .rst(rst_n), .start(start0), .len(len), .coef_we(coef_we),
        .coef_idx(coef_idx), .coef_data(coef_data), .mem(m0),
        .busy(busy0), .done(done0), .cycle_count(cc0), .sat_count(sc0));

    fir_param_engine #(.SHIFT(2)) u1 (
        .clk(clk), .rst(rst_n), .start(start1), .len(len), .coef_we(coef_we),
        .coef_idx(coef_idx), .coef_data(coef_data), .mem(m1),
        .busy(busy1), .done(done1), .cycle_count(cc1), .sat_count(sc1));

    // Sample memories: registered read on A, write on B, bulk image load.
    logic signed [7:0] mem0 [1024];
    logic signed [7:0] mem1 [1024];
    logic signed [7:0] img  [1024];
    logic load0 = 1'b0, load1 = 1'b0;
    int   wr0 = 0, wr1 = 0;

    always @(posedge clk) begin
        m0.mem_data_out_a <= mem0[m0.mem_addr_a];
        m1.mem_data_out_a <= mem1[m1.mem_addr_a];
        if (load0) mem0 <= img;
        else if (m0.mem_we_b) mem0[m0.mem_addr_b] <= m0.mem_data_in_b;
        if (load1) mem1 <= img;
        else if (m1.mem_we_b) mem1[m1.mem_addr_b] <= m1.mem_data_in_b;
        if (m0.mem_we_b) wr0 <= wr0 + 1;
        if (m1.mem_we_b) wr1 <= wr1 + 1;
    end

    int checks = 0;
    int errors = 0;
    int cur_x [64];
    int cur_h [5];
    int model_y [64];
    int model_sat;

    typedef struct {
        int inst;
        int len;
        int x [10];
        int h [5];
        int y [10];
        int sat;
    } vec_t;
    vec_t tv [5];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: direct convolution with zero history, round, clamp.
    task automatic model(input int L, input int sh);
        longint acc;
        model_sat = 0;
        for (int n = 0; n < L; n++) begin
            acc = 0;
            for (int k = 0; k < 5; k++) begin
                if (n - k >= 0) acc += longint'(cur_h[k]) * longint'(cur_x[n-k]);
            end
            if (sh > 0) acc += longint'(1) << (sh - 1);
            acc = acc >>> sh;
            if (acc > 127) begin acc = 127; model_sat++; end
            else if (acc < -128) begin acc = -128; model_sat++; end
            model_y[n] = int'(acc);
        end
    endtask

    task automatic load(input int inst, input int L);
        for (int i = 0; i < 1024; i++) img[i] = 8'sh55;
        for (int i = 0; i < L; i++) img[i] = 8'(cur_x[i]);
        load0 = (inst == 0);
        load1 = (inst == 1);
        tick();
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    task automatic run(input int inst, input int L, input bit wr_coefs, input bit disturb);
        int wbase, cyc, exp_cyc, bad;
        logic signed [7:0] v;
        load(inst, L);
        wbase = (inst == 1) ? wr1 : wr0;
        if (wr_coefs) begin
            for (int k = 0; k < 4; k++) begin
                coef_we = 1'b1; coef_idx = 3'(k); coef_data = 8'(cur_h[k]);
                tick();
            end
        end
        // Last coefficient goes in on the same edge as start.
        coef_we = wr_coefs; coef_idx = 3'd4; coef_data = 8'(cur_h[4]);
        len = AW'(L);
        start0 = (inst == 0);
        start1 = (inst == 1);
        tick();
        start0 = 1'b0; start1 = 1'b0; coef_we = 1'b0;
        cyc = 1;
        chk("busy_after_start", (inst == 1) ? busy1 : busy0, (L > 0) ? 1 : 0);
        while (!((inst == 1) ? done1 : done0) && cyc < 200) begin
            if (disturb && cyc == 3) begin
                start0 = (inst == 0); start1 = (inst == 1); len = AW'(30);
                coef_we = 1'b1; coef_idx = 3'd0; coef_data = 8'sd100;
            end else begin
                start0 = 1'b0; start1 = 1'b0; coef_we = 1'b0;
            end
            tick();
            cyc++;
        end
        start0 = 1'b0; start1 = 1'b0; coef_we = 1'b0;
        exp_cyc = (L == 0) ? 1 : L + 6;
        model(L, (inst == 1) ? 2 : 0);
        chk("done_cycle", cyc, exp_cyc);
        chk("cycle_count_at_done", (inst == 1) ? cc1 : cc0, exp_cyc);
        chk("busy_at_done", (inst == 1) ? busy1 : busy0, 0);
        chk("sat_count", (inst == 1) ? sc1 : sc0, model_sat);
        tick();
        chk("done_pulse_width", (inst == 1) ? done1 : done0, 0);
        chk("cycle_count_hold", (inst == 1) ? cc1 : cc0, exp_cyc);
        chk("write_count", ((inst == 1) ? wr1 : wr0) - wbase, L);
        bad = 0;
        for (int n = 0; n < L; n++) begin
            v = (inst == 1) ? mem1[512+n] : mem0[512+n];
            if (int'(v) != model_y[n]) bad++;
        end
        chk("model_outputs_bad", bad, 0);
        v = (inst == 1) ? mem1[512+L] : mem0[512+L];
        chk("past_end_untouched", v, 85);
    endtask

    initial begin
        int bad;
        int wbase;
        logic signed [7:0] v;

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_cycle_count", cc0, 0);
        chk("rst_sat_count", sc0, 0);
        chk("rst_we_b", m0.mem_we_b, 0);
        chk("rst_addr_a", m0.mem_addr_a, 0);
        rst_n = 1'b1;
        tick();

        tv[0].inst = 0; tv[0].len = 8;  tv[0].sat = 0;
        tv[0].x = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[0].h = '{1, 2, 3, 4, 5};
        tv[0].y = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0};
        tv[1].inst = 0; tv[1].len = 10; tv[1].sat = 7;
        tv[1].x = '{64, 64, 64, 64, 64, 0, 0, 0, 0, 0};
        tv[1].h = '{1, 1, 1, 1, 1};
        tv[1].y = '{64, 127, 127, 127, 127, 127, 127, 127, 64, 0};
        tv[2].inst = 1; tv[2].len = 4;  tv[2].sat = 0;
        tv[2].x = '{6, -6, 1, -2, 0, 0, 0, 0, 0, 0};
        tv[2].h = '{1, 0, 0, 0, 0};
        tv[2].y = '{2, -1, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[3].inst = 0; tv[3].len = 6;  tv[3].sat = 5;
        tv[3].x = '{-128, -128, -128, -128, -128, -128, 0, 0, 0, 0};
        tv[3].h = '{1, 1, 1, 1, 1};
        tv[3].y = '{-128, -128, -128, -128, -128, -128, 0, 0, 0, 0};
        tv[4].inst = 0; tv[4].len = 4;  tv[4].sat = 0;
        tv[4].x = '{10, 20, -30, 40, 0, 0, 0, 0, 0, 0};
        tv[4].h = '{-1, 2, 0, 0, 0};
        tv[4].y = '{-10, 0, 70, -100, 0, 0, 0, 0, 0, 0};

        foreach (tv[t]) begin
            for (int i = 0; i < 64; i++) cur_x[i] = (i < 10) ? tv[t].x[i] : 0;
            for (int k = 0; k < 5; k++) cur_h[k] = tv[t].h[k];
            run(tv[t].inst, tv[t].len, 1'b1, 1'b0);
            bad = 0;
            for (int n = 0; n < tv[t].len; n++) begin
                v = (tv[t].inst == 1) ? mem1[512+n] : mem0[512+n];
                if (int'(v) != tv[t].y[n]) bad++;
            end
            chk($sformatf("vec%0d_outputs_bad", t), bad, 0);
            chk($sformatf("vec%0d_sat", t), (tv[t].inst == 1) ? sc1 : sc0, tv[t].sat);
        end

        // len = 0
        run(0, 0, 1'b1, 1'b0);

        // Start and coefficient write while busy are ignored
        for (int i = 0; i < 12; i++) cur_x[i] = int'($urandom_range(0, 255)) - 128;
        cur_h = '{3, -2, 1, 0, 2};
        run(0, 12, 1'b1, 1'b1);

        // Reset mid-run
        for (int i = 0; i < 20; i++) cur_x[i] = int'($urandom_range(0, 255)) - 128;
        load(0, 20);
        len = AW'(20);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        wbase = wr0;
        rst_n = 1'b0;
        #1;
        chk("midrst_done", done0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_we_b", m0.mem_we_b, 0);
        chk("midrst_cycle_count", cc0, 0);
        tick();
        tick();
        chk("midrst_no_writes", wr0 - wbase, 0);
        rst_n = 1'b1;
        tick();
        cur_h = '{1, 1, 1, 1, 1};
        for (int i = 0; i < 15; i++) cur_x[i] = int'($urandom_range(0, 255)) - 128;
        run(0, 15, 1'b0, 1'b0);

        // Randomized runs on both instances
        for (int r = 0; r < 16; r++) begin
            int L;
            L = int'($urandom_range(1, 40));
            for (int i = 0; i < L; i++) cur_x[i] = int'($urandom_range(0, 255)) - 128;
            for (int k = 0; k < 5; k++) begin
                if (r % 3 == 0) cur_h[k] = int'($urandom_range(0, 255)) - 128;
                else cur_h[k] = int'($urandom_range(0, 8)) - 4;
            end
            run(r % 2, L, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end
endmodule
